user_proj_ha_capture: RTL and testbench



---
 rtl/user_proj_ha_capture_pkg.sv | 34 +++
 rtl/ha_capture_fifo.sv | 50 +++++
 rtl/user_proj_ha_capture.sv | 188 ++++++++++++++++++
 tb/tb_user_proj_ha_capture.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_proj_ha_capture_pkg.sv
// Shared register map, bit positions and helpers for the half-adder capture block.
package user_proj_ha_capture_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_TIMER  = 2'd3
  } reg_idx_e;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  // STATUS bit positions
  localparam int STAT_COUNT_W    = 8;
  localparam int STAT_EMPTY_BIT  = 8;
  localparam int STAT_FULL_BIT   = 9;
  localparam int STAT_OVF_BIT    = 10;

  // Replace only the bytes of old_val whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ha_capture_fifo.sv
// Synchronous FIFO with wrap-bit pointers; simultaneous push/pop allowed when full.
module ha_capture_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/user_proj_ha_capture.sv
// Wishbone-readable capture of the half-adder pad outputs with timestamped FIFO.
module user_proj_ha_capture
  import user_proj_ha_capture_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int TS_BITS = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [WIDTH-1:0]  io_in,
  output logic [WIDTH-1:0]  io_oeb,
  output logic [2:0]        irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = TS_BITS + WIDTH;

  // Capture path state
  logic [WIDTH-1:0]   s1;
  logic [WIDTH-1:0]   s2;
  logic [WIDTH-1:0]   last;
  logic               chg;

  // Control / status state
  logic               en;
  logic               irq_en;
  logic               ovf;
  logic               irq0;
  logic [TS_BITS-1:0] timer;

  // Wishbone decode
  reg_idx_e           idx;
  logic               valid;
  logic               acc;
  logic               wr;
  logic               rd;
  logic               ctrl_wr;
  logic               tmr_wr;
  logic               flush;
  logic               ovf_clr;
  logic               ovf_set;
  logic               pop;
  logic               push;
  logic [31:0]        rdat;
  logic [31:0]        timer_merged;

  // FIFO interface
  logic [EW-1:0]      fifo_din;
  logic [EW-1:0]      fifo_dout;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               unused;

  assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], timer_merged[31:TS_BITS]};

  assign idx     = reg_idx_e'(wbs_adr_i[3:2]);
  assign valid   = wbs_cyc_i && wbs_stb_i;
  // An access is taken only on the first valid cycle; the ack cycle itself is skipped.
  assign acc     = valid && !wbs_ack_o;
  assign wr      = acc && wbs_we_i;
  assign rd      = acc && !wbs_we_i;
  assign ctrl_wr = wr && (idx == REG_CTRL);
  assign tmr_wr  = wr && (idx == REG_TIMER);
  assign flush   = ctrl_wr && wbs_sel_i[0] && wbs_dat_i[CTRL_FLUSH_BIT];
  assign ovf_clr = wr && (idx == REG_STATUS) && wbs_sel_i[1] && wbs_dat_i[STAT_OVF_BIT];
  assign pop     = rd && (idx == REG_DATA);

  assign chg     = en && (s2 != last);
  assign push    = chg && !flush;
  // A dropped event is an overflow unless a same-cycle pop makes room or a flush discards it.
  assign ovf_set = chg && fifo_full && !pop && !flush;

  assign fifo_din     = {timer, s2};
  assign timer_merged = byte_merge(32'(timer), wbs_dat_i, wbs_sel_i);

  assign io_oeb = '1;
  assign irq    = {2'b00, irq0};

  ha_capture_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read-data mux for the currently addressed register.
  always_comb begin
    rdat = '0;
    case (idx)
      REG_CTRL: begin
        rdat[CTRL_EN_BIT]     = en;
        rdat[CTRL_IRQ_EN_BIT] = irq_en;
      end
      REG_STATUS: begin
        rdat[STAT_COUNT_W-1:0] = 8'(fifo_count);
        rdat[STAT_EMPTY_BIT]   = fifo_empty;
        rdat[STAT_FULL_BIT]    = fifo_full;
        rdat[STAT_OVF_BIT]     = ovf;
      end
      REG_DATA: begin
        if (!fifo_empty) begin
          rdat[WIDTH-1:0]    = fifo_dout[WIDTH-1:0];
          rdat[31 -: TS_BITS] = fifo_dout[EW-1 -: TS_BITS];
        end
      end
      REG_TIMER: begin
        rdat[TS_BITS-1:0] = timer;
      end
      default: rdat = '0;
    endcase
  end

  // Single-cycle ack and registered read data, zero outside the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdat : '0;
    end
  end

  // CTRL enable bits live in byte 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_wr && wbs_sel_i[0]) begin
      en     <= wbs_dat_i[CTRL_EN_BIT];
      irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)     ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Free-running timestamp; a bus load beats the increment.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)    timer <= '0;
    else if (tmr_wr) timer <= timer_merged[TS_BITS-1:0];
    else if (en)     timer <= timer + 1'b1;
  end

  // Two-flop synchronizer then change reference; last tracks s2 while disabled.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1   <= '0;
      s2   <= '0;
      last <= '0;
    end else begin
      s1 <= io_in;
      s2 <= s1;
      if (!en || chg) last <= s2;
    end
  end

  // Registered data-available interrupt.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq0 <= 1'b0;
    else          irq0 <= irq_en && !fifo_empty;
  end

endmodule

// File: tb/tb_user_proj_ha_capture.sv
// Self-checking bench: register table, directed corner sequences, randomized capture vs queue model.
module tb_user_proj_ha_capture;

  localparam int WIDTH   = 2;
  localparam int DEPTH   = 4;
  localparam int TS_BITS = 16;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DATA   = 2'd2;
  localparam logic [1:0] A_TIMER  = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              ack;
  logic [31:0]       rdat;
  logic [WIDTH-1:0]  io_in;
  logic [WIDTH-1:0]  io_oeb;
  logic [2:0]        irq;

  always #5 clk = ~clk;

  user_proj_ha_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_BITS(TS_BITS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: queue of expected DATA words plus flags and timer value.
  logic [31:0]      q[$];
  logic             m_ovf;
  logic             m_en;
  logic             m_irqen;
  logic [15:0]      tmr;
  logic [15:0]      ack_pre;
  logic [WIDTH-1:0] last_v;

  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_en) tmr = tmr + 16'd1;
    #1;
  endtask

  task automatic wb(input logic w, input logic [1:0] idx, input logic [31:0] wd,
                    input logic [3:0] s, output logic [31:0] d, output int lat);
    logic [15:0] pre;
    logic        got;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'h0, idx, 2'b00}; wdat = wd; sel = s;
    lat = 0; d = '0; got = 1'b0; pre = tmr;
    for (int i = 0; i < 8; i++) begin
      pre = tmr;
      tick();
      lat = i + 1;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    d = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    ack_pre = pre;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=no_ack expected=ack_within_8");
    end else if (w) begin
      case (idx)
        A_CTRL: if (s[0]) begin
          m_en = wd[0]; m_irqen = wd[1];
          if (wd[2]) q.delete();
        end
        A_STATUS: if (s[1] && wd[10]) m_ovf = 1'b0;
        A_TIMER: begin
          tmr = pre;
          if (s[0]) tmr[7:0]  = wd[7:0];
          if (s[1]) tmr[15:8] = wd[15:8];
        end
        default: ;
      endcase
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] d; int l;
    wb(1'b1, idx, wd, s, d, l);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] d; int l;
    wb(1'b0, idx, 32'h0, 4'hF, d, l);
    chk(name, d, exp);
  endtask

  task automatic chk_data(input string name);
    logic [31:0] d, exp; int l;
    exp = (q.size() > 0) ? q[0] : 32'h0;
    wb(1'b0, A_DATA, 32'h0, 4'hF, d, l);
    if (q.size() > 0) void'(q.pop_front());
    chk(name, d, exp);
  endtask

  task automatic chk_status(input string name);
    logic [31:0] exp;
    exp = '0;
    exp[7:0] = 8'(q.size());
    exp[8]   = (q.size() == 0);
    exp[9]   = (q.size() == DEPTH);
    exp[10]  = m_ovf;
    rd_chk(name, A_STATUS, exp);
  endtask

  task automatic chk_timer(input string name);
    logic [31:0] d; int l;
    wb(1'b0, A_TIMER, 32'h0, 4'hF, d, l);
    chk(name, d, {16'h0, ack_pre});
  endtask

  // Drive a pad value and let it settle through capture; record the expected entry.
  task automatic pad(input logic [WIDTH-1:0] v);
    io_in = v;
    if (m_en && v != last_v) begin
      if (q.size() < DEPTH) q.push_back({tmr + 16'd2, 14'h0, v});
      else                  m_ovf = 1'b1;
    end
    last_v = v;
    repeat (4) tick();
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_irqen = 1'b0; m_ovf = 1'b0; tmr = 16'h0;
    q.delete(); last_v = io_in;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic add_vec(input logic w, input logic [1:0] idx, input logic [31:0] wd,
                         input logic [3:0] s, input logic [31:0] exp, input string name);
    vec_t v;
    v.we = w; v.idx = idx; v.wd = wd; v.sel = s; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0]      d;
    int               lat;
    logic [WIDTH-1:0] v;
    logic [31:0]      newe;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; wdat = '0; io_in = '0;
    model_reset();

    // Reset defaults
    do_reset();
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_oeb", {30'h0, io_oeb}, 32'h3);
    chk("rst_irq", {29'h0, irq}, 32'h0);
    wb(1'b0, A_STATUS, 32'h0, 4'hF, d, lat);
    chk("rst_status", d, 32'h100);
    chk("rst_ack_latency", lat, 32'd1);

    // Register table
    add_vec(1'b0, A_CTRL,   32'h0,        4'hF, 32'h0,    "tbl_ctrl_rst");
    add_vec(1'b1, A_CTRL,   32'h2,        4'hF, 32'h0,    "");
    add_vec(1'b0, A_CTRL,   32'h0,        4'hF, 32'h2,    "tbl_ctrl_irqen");
    add_vec(1'b1, A_CTRL,   32'h3,        4'h0, 32'h0,    "");
    add_vec(1'b0, A_CTRL,   32'h0,        4'hF, 32'h2,    "tbl_ctrl_sel0");
    add_vec(1'b1, A_CTRL,   32'h4,        4'h1, 32'h0,    "");
    add_vec(1'b0, A_CTRL,   32'h0,        4'hF, 32'h0,    "tbl_ctrl_flush_rd0");
    add_vec(1'b1, A_TIMER,  32'h1234,     4'h1, 32'h0,    "");
    add_vec(1'b0, A_TIMER,  32'h0,        4'hF, 32'h34,   "tbl_timer_b0");
    add_vec(1'b1, A_TIMER,  32'hAB00,     4'h2, 32'h0,    "");
    add_vec(1'b0, A_TIMER,  32'h0,        4'hF, 32'hAB34, "tbl_timer_b1");
    add_vec(1'b1, A_DATA,   32'hFFFFFFFF, 4'hF, 32'h0,    "");
    add_vec(1'b0, A_DATA,   32'h0,        4'hF, 32'h0,    "tbl_data_empty");
    add_vec(1'b0, A_STATUS, 32'h0,        4'hF, 32'h100,  "tbl_status");
    add_vec(1'b1, A_TIMER,  32'h0,        4'hF, 32'h0,    "");
    add_vec(1'b0, A_TIMER,  32'h0,        4'hF, 32'h0,    "tbl_timer_zero");
    foreach (tbl[i]) begin
      wb(tbl[i].we, tbl[i].idx, tbl[i].wd, tbl[i].sel, d, lat);
      if (!tbl[i].we) chk(tbl[i].name, d, tbl[i].exp);
    end

    // Single capture: changes land at timestamps 5 and 12
    wr(A_CTRL, 32'h3, 4'hF);
    repeat (3) tick();
    pad(2'b01);
    repeat (3) tick();
    chk("cap_irq_up", {31'h0, irq[0]}, 32'h1);
    pad(2'b11);
    rd_chk("cap_status", A_STATUS, 32'h2);
    rd_chk("cap_data0", A_DATA, 32'h0005_0001);
    rd_chk("cap_data1", A_DATA, 32'h000C_0003);
    q.delete();
    chk("cap_irq_hold", {31'h0, irq[0]}, 32'h1);
    tick();
    chk("cap_irq_fall", {31'h0, irq[0]}, 32'h0);
    rd_chk("cap_data_empty", A_DATA, 32'h0);
    rd_chk("cap_status_empty", A_STATUS, 32'h100);

    // Overflow: five changes into four slots
    pad(2'b10); pad(2'b01); pad(2'b10); pad(2'b01); pad(2'b10);
    rd_chk("ovf_status", A_STATUS, 32'h604);
    wr(A_STATUS, 32'h400, 4'h2);
    rd_chk("ovf_w1c", A_STATUS, 32'h204);
    for (int i = 0; i < 4; i++) chk_data("ovf_data");
    chk_status("ovf_drained");

    // Full FIFO with push and pop on the same edge
    pad(2'b01); pad(2'b10); pad(2'b01); pad(2'b10);
    chk_status("pp_full");
    v = 2'b11;
    io_in = v; last_v = v;
    newe = {tmr + 16'd2, 14'h0, v};
    tick(); tick();
    chk_data("pp_data");
    q.push_back(newe);
    repeat (2) tick();
    rd_chk("pp_status", A_STATUS, 32'h204);

    // Flush coinciding with an in-flight push into a full FIFO
    v = 2'b00;
    io_in = v; last_v = v;
    tick(); tick();
    wr(A_CTRL, 32'h7, 4'h1);
    repeat (2) tick();
    rd_chk("flush_status", A_STATUS, 32'h100);

    // Disabled: no captures, timer held
    wr(A_CTRL, 32'h0, 4'hF);
    chk_timer("dis_timer0");
    pad(2'b01); pad(2'b10); pad(2'b11);
    rd_chk("dis_status", A_STATUS, 32'h100);
    chk_timer("dis_timer1");

    // Timer wrap
    wr(A_CTRL, 32'h1, 4'hF);
    wr(A_TIMER, 32'hFFFF, 4'h3);
    rd_chk("tmr_wrap", A_TIMER, 32'h0);

    // Reset during an outstanding strobe with two entries queued
    pad(2'b00); pad(2'b01);
    chk_status("mid_two");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {28'h0, A_DATA, 2'b00}; sel = 4'hF;
    rst = 1'b1; m_en = 1'b0;
    tick();
    chk("mid_rst_ack0", {31'h0, ack}, 32'h0);
    tick();
    chk("mid_rst_ack1", {31'h0, ack}, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    rd_chk("mid_status", A_STATUS, 32'h100);
    rd_chk("mid_ctrl", A_CTRL, 32'h0);
    chk("mid_irq", {29'h0, irq}, 32'h0);

    // Randomized capture/drain against the queue model
    wr(A_CTRL, 32'h3, 4'hF);
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pad(WIDTH'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 3)) tick();
      end
      chk("rnd_irq", {31'h0, irq[0]}, {31'h0, m_irqen && (q.size() > 0)});
      chk_status("rnd_status");
      if (m_ovf && $urandom_range(0, 1) == 1) wr(A_STATUS, 32'h400, 4'h2);
      repeat ($urandom_range(0, 5)) chk_data("rnd_data");
      if ($urandom_range(0, 7) == 0) wr(A_TIMER, $urandom, 4'hF);
      if ($urandom_range(0, 7) == 0) wr(A_CTRL, 32'($urandom_range(0, 7)), 4'hF);
      if ($urandom_range(0, 5) == 0) wr(A_CTRL, 32'h3, 4'hF);
    end
    while (q.size() > 0) chk_data("rnd_drain");
    chk_status("rnd_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
